// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two core requesters, the arbiter and the word memory.
interface mem_port_arbiter_if #(
  parameter int MEM_WIDTH = 16
);
  // instruction-fetch requester
  logic                 i_req;
  logic [31:0]          i_addr;
  logic                 i_gnt;
  logic                 i_rvalid;
  logic [31:0]          i_rdata;
  logic                 i_err;
  // load/store requester
  logic                 d_req;
  logic                 d_we;
  logic [31:0]          d_addr;
  logic [31:0]          d_wdata;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [31:0]          d_rdata;
  logic                 d_err;
  // single-ported memory
  logic                 m_en;
  logic                 m_we;
  logic [MEM_WIDTH-1:0] m_addr;
  logic [31:0]          m_wdata;
  logic [31:0]          m_rdata;

  // arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_en, m_we, m_addr, m_wdata
  );

  // requester / memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter in front of a single-ported word memory.
// Data wins conflicts until fetch has been denied STARVE_LIMIT cycles in a row.
// Responses return one cycle after the grant; bad addresses are granted but
// never reach the memory and come back as an error response instead.
module mem_port_arbiter #(
  parameter int MEM_WIDTH    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int            SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          pending_i_q, pending_i_d;
  logic          pending_d_q, pending_d_d;
  logic          err_i_q, err_i_d;
  logic          err_d_q, err_d_d;

  logic          gnt_i, gnt_d, any_gnt, addr_err, mem_en, mem_we;
  logic [31:0]   sel_addr;

  // Arbitration: data by default, fetch once its denial streak hits the limit
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!rst) begin
      gnt_i = bus.i_req && (!bus.d_req || (starve_cnt_q == LIMIT));
      gnt_d = bus.d_req && !gnt_i;
    end
  end

  // Address check on whichever request won: misaligned or beyond the memory
  always_comb begin
    sel_addr = gnt_i ? bus.i_addr : bus.d_addr;
    addr_err = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (MEM_WIDTH + 2)) != 32'd0);
  end

  assign any_gnt = gnt_i || gnt_d;
  assign mem_en  = any_gnt && !addr_err;
  assign mem_we  = mem_en && gnt_d && bus.d_we;

  assign bus.i_gnt   = gnt_i;
  assign bus.d_gnt   = gnt_d;
  assign bus.m_en    = mem_en;
  assign bus.m_we    = mem_we;
  assign bus.m_addr  = mem_en ? sel_addr[MEM_WIDTH+1:2] : '0;
  assign bus.m_wdata = mem_we ? bus.d_wdata : 32'd0;

  // Next state: saturating starvation streak and per-requester response flags
  always_comb begin
    starve_cnt_d = '0;
    if (bus.i_req && !gnt_i)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    pending_i_d = gnt_i && !addr_err;
    err_i_d     = gnt_i && addr_err;
    // legal stores complete silently; only loads and errors answer
    pending_d_d = gnt_d && !addr_err && !bus.d_we;
    err_d_d     = gnt_d && addr_err;
  end

  // State registers; reset kills any response still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      pending_i_q  <= 1'b0;
      pending_d_q  <= 1'b0;
      err_i_q      <= 1'b0;
      err_d_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pending_i_q  <= pending_i_d;
      pending_d_q  <= pending_d_d;
      err_i_q      <= err_i_d;
      err_d_q      <= err_d_d;
    end
  end

  // Responses: memory read data steered to whoever was granted last cycle
  assign bus.i_rvalid = pending_i_q || err_i_q;
  assign bus.i_err    = err_i_q;
  assign bus.i_rdata  = pending_i_q ? bus.m_rdata : 32'd0;
  assign bus.d_rvalid = pending_d_q || err_d_q;
  assign bus.d_err    = err_d_q;
  assign bus.d_rdata  = pending_d_q ? bus.m_rdata : 32'd0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported word memory between the core's instruction-fetch requester and its load/store requester. Both requesters use a req/gnt handshake. Granted accesses go to the memory port at most one per cycle. Read data and an error flag return to the issuing requester exactly one cycle after the grant. Data accesses win conflicts by default, and a starvation counter guarantees fetch progress.

## Interface
- MEM_WIDTH, 16, word-address bits driven to the memory; legal byte addresses are 0 .. 4*2^MEM_WIDTH-1
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch gets priority; 0 = fetch always has priority
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; addr held stable until granted
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch response valid
- i_rdata  out  32  fetch read data
- i_err  out  1  fetch response is an error (misaligned or out of range)
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_rvalid  out  1  load response valid; also pulses for an erroring store
- d_rdata  out  32  load data
- d_err  out  1  data response is an error
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  MEM_WIDTH  word address = byte addr[MEM_WIDTH+1:2]
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after an m_en read

## Operation
- Arbitration each cycle, with starve_cnt as the internal counter:
  - Only one requester active: that requester is granted.
  - Both active, starve_cnt < STARVE_LIMIT: data is granted.
  - Both active, starve_cnt == STARVE_LIMIT: fetch is granted.
  - Neither active: no grant, m_en = 0.
- starve_cnt behaviour:
  - Increments, saturating at STARVE_LIMIT, on each cycle with i_req && !i_gnt.
  - Clears on any cycle with i_gnt, or with !i_req.
  - Width is clog2(STARVE_LIMIT+1), minimum 1.
- Error check is done on the granted address:
  - Misaligned: addr[1:0] != 0.
  - Out of range: any of addr[31:MEM_WIDTH+2] set.
- Errored access:
  - Is still granted, but m_en = 0.
  - Next cycle, the requester's rvalid = 1 with err = 1 and rdata = 0.
  - Applies to stores too.
- Legal read: m_en = 1, m_we = 0. Next cycle, rvalid = 1, err = 0, rdata = m_rdata.
- Legal store: m_en = 1, m_we = 1, m_wdata = d_wdata. No response.
- Response routing uses registered flags captured at grant: pending_i, pending_d, err_i, err_d.
  - The rdata outputs are m_rdata gated by the matching pending flag, otherwise 0.
- Requesters must accept responses unconditionally; there is no response backpressure.
- Grants are issued in order. A load granted the cycle after a store to the same word returns the stored value.

## Timing
- During rst, and as reset values:
  - i_gnt = d_gnt = 0.
  - m_en = m_we = 0; m_addr = 0; m_wdata = 0.
  - All rvalid/err/rdata = 0.
  - starve_cnt = 0; pending flags = 0.
- gnt and m_* outputs are combinational from req, addr, we, starve_cnt. They are forced 0 while rst is high.
- The first grant is possible in the first cycle after rst falls.
- Throughput is one grant per cycle, with no bubbles between back-to-back grants to either requester.
- Latency is grant edge + 1 cycle to rvalid. rvalid is a single-cycle pulse per granted read or error.
- Reset mid-operation: flags for a pending read are cleared asynchronously, and no rvalid is emitted after rst falls.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: fetch is granted and starve_cnt clears in the same edge. Data is granted the next cycle if still requesting.

## Test plan
- Reset: rst high 20 ns, i_req = 1, addr 0.
  - During reset: all outputs 0.
  - First cycle after release: i_gnt = 1, m_en = 1, m_addr = 0.
  - Next cycle: i_rvalid = 1, i_rdata = mem[0].
- Fetch stream: i_req continuous, addrs 0, 4, 8.
  - Three consecutive i_gnt.
  - i_rvalid on the three following cycles with mem[0], mem[1], mem[2].
- Conflict with STARVE_LIMIT = 4: both requesting continuously.
  - d_gnt in cycles 1-4.
  - i_gnt in cycle 5 with d_gnt = 0.
  - d_gnt in cycle 6.
- Store/load: store 0xDEADBEEF to 0x100, then load 0x100.
  - m_addr = 0x40 for both accesses.
  - No d_rvalid after the store.
  - d_rvalid with d_rdata = 0xDEADBEEF after the load.
- Errors, with MEM_WIDTH = 16:
  - d_addr = 0x102: d_gnt = 1, m_en = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0.
  - i_addr = 0x0004_0000: same error response on i_rvalid/i_err.
- Reset mid-read: assert rst in the cycle after an i_gnt. i_rvalid stays 0 throughout and after release.
